// File: rtl/l0_skew_feeder_if.sv
// Bus between the skew feeder and whoever drives it.
// The master side writes vectors and launches reads; the slave side is the feeder.
interface l0_skew_feeder_if #(
    parameter int unsigned row = 8,
    parameter int unsigned bw  = 4
);
    logic                wr;
    logic [row*bw-1:0]   in;
    logic                rd;
    logic [1:0]          inst_in;
    logic [row*bw-1:0]   out;
    logic [row*2-1:0]    inst_out;
    logic [row-1:0]      valid_out;
    logic                o_full;
    logic                o_ready;
    logic                o_empty;
    logic                o_underflow;

    modport master (
        output wr, in, rd, inst_in,
        input  out, inst_out, valid_out, o_full, o_ready, o_empty, o_underflow
    );

    modport slave (
        input  wr, in, rd, inst_in,
        output out, inst_out, valid_out, o_full, o_ready, o_empty, o_underflow
    );
endinterface

// File: rtl/l0_skew_feeder.sv
// Per-row input FIFOs west of the MAC array; a read wavefront pops row i
// i cycles after row 0, carrying the instruction alongside each row's data.
module l0_skew_feeder #(
    parameter int unsigned row   = 8,
    parameter int unsigned bw    = 4,
    parameter int unsigned depth = 16
) (
    input  logic              clk,
    input  logic              reset,
    l0_skew_feeder_if.slave   bus
);
    localparam int unsigned AW = $clog2(depth);
    localparam int unsigned CW = AW + 1;

    logic [bw-1:0]      mem   [row][depth];
    logic [AW-1:0]      wptr  [row];
    logic [AW-1:0]      rptr  [row];
    logic [CW-1:0]      count [row];

    logic [row-2:0]     rd_q;
    logic [row-1:0]     rd_d;
    logic [2*row-3:0]   inst_q;
    logic [2*row-1:0]   inst_d;

    logic               push;
    logic               full;
    logic               empty;
    logic [row-1:0]     pop;
    logic [row-1:0]     pop_empty;

    logic [row*bw-1:0]  out_q;
    logic [row*2-1:0]   inst_out_q;
    logic [row-1:0]     valid_q;
    logic               underflow_q;

    // Tap i of the skew line is the rd seen i cycles ago; tap 0 is the live input.
    assign rd_d   = {rd_q, bus.rd};
    assign inst_d = {inst_q, bus.inst_in};

    always_comb begin
        full      = 1'b0;
        empty     = 1'b1;
        pop       = '0;
        pop_empty = '0;
        for (int unsigned i = 0; i < row; i++) begin
            full         = full  | (count[i] == CW'(depth));
            empty        = empty & (count[i] == '0);
            pop[i]       = rd_d[i] & (count[i] != '0);
            pop_empty[i] = rd_d[i] & (count[i] == '0);
        end
        // A full row blocks the write for every row, even if it pops this cycle.
        push = bus.wr & ~full;
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            for (int unsigned i = 0; i < row; i++) begin
                mem[i][wptr[i]] <= bus.in[i*bw +: bw];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q        <= '0;
            inst_q      <= '0;
            out_q       <= '0;
            inst_out_q  <= '0;
            valid_q     <= '0;
            underflow_q <= 1'b0;
            for (int unsigned i = 0; i < row; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
        end else begin
            rd_q        <= rd_d[row-2:0];
            inst_q      <= inst_d[2*row-3:0];
            valid_q     <= pop;
            underflow_q <= underflow_q | (|pop_empty);
            for (int unsigned i = 0; i < row; i++) begin
                if (push) begin
                    wptr[i] <= wptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rptr[i] <= rptr[i] + 1'b1;
                end
                case ({push, pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
                out_q[i*bw +: bw]    <= pop[i] ? mem[i][rptr[i]] : '0;
                inst_out_q[i*2 +: 2] <= pop[i] ? inst_d[i*2 +: 2] : 2'b00;
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.inst_out    = inst_out_q;
    assign bus.valid_out   = valid_q;
    assign bus.o_full      = full;
    assign bus.o_ready     = ~full;
    assign bus.o_empty     = empty;
    assign bus.o_underflow = underflow_q;
endmodule

// File: tb/tb_l0_skew_feeder.sv
// Directed bench for l0_skew_feeder: wavefront timing, full/empty limits,
// underflow stickiness, pointer wrap and reset during a wavefront.
module tb_l0_skew_feeder;
    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    l0_skew_feeder_if #(.row(ROW), .bw(BW)) bus ();

    l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row i of vector k holds (3k + i) mod 16: distinct per row and per vector.
    function automatic logic [BW-1:0] vec_row(input int k, input int i);
        return BW'(3 * k + i);
    endfunction

    function automatic logic [ROW*BW-1:0] vec(input int k);
        logic [ROW*BW-1:0] v;
        for (int i = 0; i < ROW; i++) v[i*BW +: BW] = vec_row(k, i);
        return v;
    endfunction

    task automatic do_reset();
        bus.wr = 1'b0; bus.rd = 1'b0; bus.inst_in = 2'b00; bus.in = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic fill(input int n, input int base);
        for (int j = 0; j < n; j++) begin
            bus.wr = 1'b1;
            bus.in = vec(base + j);
            tick();
        end
        bus.wr = 1'b0;
    endtask

    // rd held for nrd cycles; rows hold nfill entries starting at vector kb.
    // Optional concurrent writes of vec(wbase + n) for the first nwr cycles.
    task automatic run_wave(input string tag, input int nrd, input int nfill, input int kb,
                            input logic [1:0] ins, input int nwr, input int wbase,
                            input int uf_at);
        logic [ROW*BW-1:0] eo;
        logic [ROW*2-1:0]  ei;
        logic [ROW-1:0]    ev;
        int k;
        for (int c = 1; c <= nrd + ROW - 1; c++) begin
            bus.rd      = (c <= nrd);
            bus.inst_in = (c <= nrd) ? ins : 2'b00;
            bus.wr      = (c <= nwr);
            bus.in      = vec(wbase + c - 1);
            tick();
            bus.rd = 1'b0; bus.wr = 1'b0; bus.inst_in = 2'b00;
            eo = '0; ei = '0; ev = '0;
            for (int i = 0; i < ROW; i++) begin
                k = c - 1 - i;
                if (k >= 0 && k < nrd && k < nfill) begin
                    ev[i]          = 1'b1;
                    eo[i*BW +: BW] = vec_row(kb + k, i);
                    ei[i*2 +: 2]   = ins;
                end
            end
            check({tag, "_valid"}, 64'(bus.valid_out), 64'(ev));
            check({tag, "_out"},   64'(bus.out),       64'(eo));
            check({tag, "_inst"},  64'(bus.inst_out),  64'(ei));
            check({tag, "_uf"},    64'(bus.o_underflow), 64'((uf_at != 0 && c >= uf_at)));
        end
    endtask

    initial begin
        bus.wr = 1'b0; bus.rd = 1'b0; bus.inst_in = 2'b00; bus.in = '0;

        // 1: reset state
        do_reset();
        tick();
        check("rst_out",   64'(bus.out), 64'd0);
        check("rst_inst",  64'(bus.inst_out), 64'd0);
        check("rst_valid", 64'(bus.valid_out), 64'd0);
        check("rst_full",  64'(bus.o_full), 64'd0);
        check("rst_ready", 64'(bus.o_ready), 64'd1);
        check("rst_empty", 64'(bus.o_empty), 64'd1);
        check("rst_uf",    64'(bus.o_underflow), 64'd0);

        // 2: single skewed read
        fill(3, 0);
        check("t2_empty0", 64'(bus.o_empty), 64'd0);
        run_wave("t2", 1, 3, 0, 2'b10, 0, 0, 0);
        check("t2_empty1", 64'(bus.o_empty), 64'd0);

        // 3: fill to depth, ignored extra writes, full drain
        do_reset();
        fill(15, 0);
        check("t3_full15",  64'(bus.o_full), 64'd0);
        fill(1, 15);
        check("t3_full16",  64'(bus.o_full), 64'd1);
        check("t3_ready16", 64'(bus.o_ready), 64'd0);
        fill(1, 40);
        check("t3_full17",  64'(bus.o_full), 64'd1);
        run_wave("t3", 16, 16, 0, 2'b10, 1, 16, 0);
        check("t3_empty",   64'(bus.o_empty), 64'd1);
        check("t3_ready",   64'(bus.o_ready), 64'd1);

        // 4: underflow on the third scheduled pop
        do_reset();
        fill(2, 5);
        run_wave("t4", 3, 2, 5, 2'b01, 0, 0, 3);
        tick();
        check("t4_uf_sticky", 64'(bus.o_underflow), 64'd1);
        check("t4_empty",     64'(bus.o_empty), 64'd1);

        // 5: streaming push+pop with pointer wrap, then drain the 4 left
        do_reset();
        fill(4, 0);
        run_wave("t5", 30, 34, 0, 2'b11, 30, 4, 0);
        check("t5_empty0", 64'(bus.o_empty), 64'd0);
        check("t5_full",   64'(bus.o_full), 64'd0);
        run_wave("t5d", 4, 4, 30, 2'b10, 0, 0, 0);
        check("t5_empty1", 64'(bus.o_empty), 64'd1);

        // 6: reset in the middle of a wavefront
        do_reset();
        fill(8, 2);
        bus.rd = 1'b1; bus.inst_in = 2'b10;
        tick();
        bus.rd = 1'b0; bus.inst_in = 2'b00;
        check("t6_v0",   64'(bus.valid_out), 64'h1);
        check("t6_out0", 64'(bus.out), 64'(vec_row(2, 0)));
        tick();
        check("t6_v1",   64'(bus.valid_out), 64'h2);
        check("t6_out1", 64'(bus.out), 64'(vec_row(2, 1)) << BW);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_valid", 64'(bus.valid_out), 64'd0);
        check("t6_rst_out",   64'(bus.out), 64'd0);
        check("t6_rst_empty", 64'(bus.o_empty), 64'd1);
        for (int c = 0; c < ROW; c++) begin
            tick();
            check("t6_idle_valid", 64'(bus.valid_out), 64'd0);
        end
        check("t6_uf",    64'(bus.o_underflow), 64'd0);
        check("t6_empty", 64'(bus.o_empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
